seg7_scan_reader: RTL

//  Monitors a multiplexed 7-segment display bus (segment lines + one-hot digit

---
 rtl/seg7_scan_reader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seg7_scan_reader                                                 |
// | Purpose : recovers hex digits from a multiplexed 7-segment bus (loopback). |
// | Option  : SEG7_DP_EN adds dp_in / dp_out decimal-point tracking.           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seg7_scan_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   an_in,
  input  logic                err_clr,
`ifdef SEG7_DP_EN
  input  logic                dp_in,
  output logic [DIGITS-1:0]   dp_out,
`endif
  output logic [4*DIGITS-1:0] digits_out,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                upd_strb,
  output logic                err
);

`ifdef SEG7_DP_EN
  localparam int KW = DIGITS + 8;
`else
  localparam int KW = DIGITS + 7;
`endif
  localparam int            CW           = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] c_STABLE_CNT = CW'(STABLE_CYC);
  localparam logic [CW-1:0] c_ONE        = CW'(1);

  // Returns {legal, value}; blank and unknown patterns both report illegal.
  function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
    case (seg)
      7'b0111111: return {1'b1, 4'h0};
      7'b0011000: return {1'b1, 4'h1};
      7'b1110110: return {1'b1, 4'h2};
      7'b1111100: return {1'b1, 4'h3};
      7'b1011001: return {1'b1, 4'h4};
      7'b1101101: return {1'b1, 4'h5};
      7'b1101111: return {1'b1, 4'h6};
      7'b0111000: return {1'b1, 4'h7};
      7'b1111111: return {1'b1, 4'h8};
      7'b1111001: return {1'b1, 4'h9};
      7'b1111011: return {1'b1, 4'hA};
      7'b1001111: return {1'b1, 4'hB};
      7'b0100111: return {1'b1, 4'hC};
      7'b1011110: return {1'b1, 4'hD};
      7'b1100111: return {1'b1, 4'hE};
      7'b1100011: return {1'b1, 4'hF};
      default:    return 5'b0;
    endcase
  endfunction

  logic [KW-1:0]       key_d, key_q, prev_q;
  logic [CW-1:0]       cnt_d, cnt_q;
  logic [4*DIGITS-1:0] digits_d, digits_q;
  logic [DIGITS-1:0]   valid_d, valid_q;
  logic                strb_d, strb_q;
  logic                err_d, err_q;
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]   dp_d, dp_q;
  logic                dp_s;
`endif

  logic [DIGITS-1:0]   an_s;
  logic [6:0]          seg_s;
  logic                same, onehot, fire, blank, err_set, chg;
  logic [4:0]          dec;

`ifdef SEG7_DP_EN
  assign key_d = {dp_in, an_in, seg_in};
  assign dp_s  = key_q[KW-1];
`else
  assign key_d = {an_in, seg_in};
`endif
  assign seg_s  = key_q[6:0];
  assign an_s   = key_q[7 +: DIGITS];
  assign same   = (key_q == prev_q);
  assign onehot = (an_s != '0) && ((an_s & (an_s - 1'b1)) == '0);
  assign dec    = seg7_decode(seg_s);
  assign blank  = (seg_s == 7'd0);

  // Decode fires only on the transition into the saturated count.
  always_comb begin
    cnt_d = '0;
    fire  = 1'b0;
    if (onehot) begin
      if (same) begin
        cnt_d = (cnt_q == c_STABLE_CNT) ? c_STABLE_CNT : cnt_q + c_ONE;
        fire  = (cnt_q == c_STABLE_CNT - c_ONE);
      end else begin
        cnt_d = c_ONE;
        fire  = (STABLE_CYC == 1);
      end
    end
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    strb_d   = 1'b0;
    err_set  = 1'b0;
    chg      = 1'b0;
`ifdef SEG7_DP_EN
    dp_d     = dp_q;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (fire && an_s[i]) begin
        if (dec[4]) begin
          chg = (dec[3:0] != digits_q[4*i +: 4]) || !valid_q[i];
`ifdef SEG7_DP_EN
          chg = chg || (dp_s != dp_q[i]);
          dp_d[i] = dp_s;
`endif
          digits_d[4*i +: 4] = dec[3:0];
          valid_d[i]         = 1'b1;
          strb_d             = chg;
        end else begin
          valid_d[i] = 1'b0;
          err_set    = !blank;
        end
      end
    end
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q    <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      strb_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEG7_DP_EN
      dp_q     <= '0;
`endif
    end else begin
      key_q    <= key_d;
      prev_q   <= key_q;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      strb_q   <= strb_d;
      err_q    <= err_d;
`ifdef SEG7_DP_EN
      dp_q     <= dp_d;
`endif
    end
  end

  assign digits_out  = digits_q;
  assign digit_valid = valid_q;
  assign upd_strb    = strb_q;
  assign err         = err_q;
`ifdef SEG7_DP_EN
  assign dp_out      = dp_q;
`endif

endmodule
`default_nettype wire
